// File: rtl/fft_out_reorder_if.sv
// Stream bundle for fft_out_reorder: pair-wide write side, sample-wide read side.
// master drives in_* data/valid/start and out_ready; slave answers with the rest.
interface fft_out_reorder_if #(
    parameter int DW    = 16,
    parameter int LOG2N = 6
);
    logic             in_valid;
    logic             in_ready;
    logic             in_start;
    logic [DW-1:0]    in_re0;
    logic [DW-1:0]    in_im0;
    logic [DW-1:0]    in_re1;
    logic [DW-1:0]    in_im1;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_re;
    logic [DW-1:0]    out_im;
    logic [LOG2N-1:0] out_idx;
    logic             out_first;
    logic             out_last;
    logic             frame_err;

    modport master (
        output in_valid, in_start, in_re0, in_im0, in_re1, in_im1,
        output out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx,
        input  out_first, out_last, frame_err
    );

    modport slave (
        input  in_valid, in_start, in_re0, in_im0, in_re1, in_im1,
        input  out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx,
        output out_first, out_last, frame_err
    );
endinterface

// File: rtl/fft_out_reorder.sv
// FFT output reorder: ping-pong banks, pair write in (bit-reversed) order, natural-order drain.
// Ports: clk, rst (async, active-high); bus = fft_out_reorder_if.slave (in pairs, out samples, frame_err).
module fft_out_reorder #(
    parameter int DW     = 16,
    parameter int LOG2N  = 6,
    parameter int BITREV = 1
) (
    input logic              clk,
    input logic              rst,
    fft_out_reorder_if.slave bus
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-2:0] LAST_PAIR = '1;
    localparam logic [LOG2N-1:0] LAST_IDX  = '1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_st_t;

    bank_st_t st_q [2];
    bank_st_t st_d [2];

    logic             wr_bank_q;
    logic             rd_bank_q;
    logic             out_bank_q;
    logic             frame_open_q;
    logic [LOG2N-2:0] wr_cnt_q;
    logic [LOG2N-1:0] rd_idx_q;

    logic             out_valid_q;
    logic [DW-1:0]    out_re_q;
    logic [DW-1:0]    out_im_q;
    logic [LOG2N-1:0] out_idx_q;
    logic             frame_err_q;

    logic [2*DW-1:0]  mem [2][N];
    logic [2*DW-1:0]  rd_word;

    logic             in_acc;
    logic             wr_en;
    logic             wr_done;
    logic [LOG2N-2:0] wr_pair;
    logic             out_take;
    logic             ld_ok;
    logic             load;

    function automatic logic [LOG2N-1:0] bin_of(input logic [LOG2N-1:0] p);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = p[LOG2N-1-i];
        end
        return (BITREV != 0) ? r : p;
    endfunction

    // Held low during reset even though the banks already read EMPTY.
    assign bus.in_ready = !rst &&
                          (st_q[wr_bank_q] == EMPTY ||
                           st_q[wr_bank_q] == FILLING);

    assign in_acc  = bus.in_valid & bus.in_ready;
    // Pairs outside an open frame are dropped unless they open one.
    assign wr_en   = in_acc & (bus.in_start | frame_open_q);
    assign wr_pair = bus.in_start ? '0 : wr_cnt_q;
    assign wr_done = wr_en & (wr_pair == LAST_PAIR);

    assign rd_word  = mem[rd_bank_q][rd_idx_q];
    assign out_take = out_valid_q & bus.out_ready;
    // Idx 0 needs a completed bank; later indices continue the bank in flight.
    assign ld_ok    = (rd_idx_q == '0) ? (st_q[rd_bank_q] == FULL) : 1'b1;
    assign load     = ld_ok & (!out_valid_q | bus.out_ready);

    // Write and read sides never touch the same bank in one cycle:
    // the writer owns EMPTY/FILLING, the reader owns FULL/DRAINING.
    always_comb begin
        st_d = st_q;
        if (wr_en) begin
            st_d[wr_bank_q] = wr_done ? FULL : FILLING;
        end
        if (load && rd_idx_q == '0) begin
            st_d[rd_bank_q] = DRAINING;
        end
        if (out_take && out_idx_q == LAST_IDX) begin
            st_d[out_bank_q] = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= '{EMPTY, EMPTY};
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            out_bank_q   <= 1'b0;
            frame_open_q <= 1'b0;
            wr_cnt_q     <= '0;
            rd_idx_q     <= '0;
            out_valid_q  <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            out_idx_q    <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            st_q        <= st_d;
            frame_err_q <= in_acc & bus.in_start & frame_open_q;

            if (wr_en) begin
                if (wr_done) begin
                    frame_open_q <= 1'b0;
                    wr_cnt_q     <= '0;
                    wr_bank_q    <= ~wr_bank_q;
                end else begin
                    frame_open_q <= 1'b1;
                    wr_cnt_q     <= wr_pair + (LOG2N-1)'(1);
                end
            end

            // Read pointer moves to the other bank as soon as the last
            // sample is loaded, so the next bank follows without a bubble.
            if (load) begin
                out_valid_q <= 1'b1;
                out_re_q    <= rd_word[2*DW-1:DW];
                out_im_q    <= rd_word[DW-1:0];
                out_idx_q   <= rd_idx_q;
                out_bank_q  <= rd_bank_q;
                rd_idx_q    <= rd_idx_q + LOG2N'(1);
                if (rd_idx_q == LAST_IDX) begin
                    rd_bank_q <= ~rd_bank_q;
                end
            end else if (out_take) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank_q][bin_of({wr_pair, 1'b0})] <= {bus.in_re0, bus.in_im0};
            mem[wr_bank_q][bin_of({wr_pair, 1'b1})] <= {bus.in_re1, bus.in_im1};
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_first = out_valid_q & (out_idx_q == '0);
    assign bus.out_last  = out_valid_q & (out_idx_q == LAST_IDX);
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: default (N=64, bitrev) and N=8 natural-order instances.
// Directed frames push expected samples; per-instance monitors pop and compare on each transfer.
module tb_fft_out_reorder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fft_out_reorder_if #(.DW(16), .LOG2N(6)) bus_a ();
    fft_out_reorder_if #(.DW(16), .LOG2N(3)) bus_b ();

    fft_out_reorder #(.DW(16), .LOG2N(6), .BITREV(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    fft_out_reorder #(.DW(16), .LOG2N(3), .BITREV(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        int          idx;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   acc_cyc[$];
    int   take_cyc[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   errcnt = 0;
    logic bp_on   = 1'b0;
    logic bp_rdy  = 1'b1;
    logic rdy_man = 1'b1;
    int   ph = 0;

    assign bus_a.out_ready = bp_on ? bp_rdy : rdy_man;
    assign bus_b.out_ready = 1'b1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    task automatic die(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
        summary();
        $fatal(1, "bench aborted");
    endtask

    function automatic logic [5:0] br6(input int p);
        logic [5:0] v;
        logic [5:0] r;
        v = 6'(p);
        for (int i = 0; i < 6; i++) r[i] = v[5-i];
        return r;
    endfunction

    // out_ready pattern 1,0,0,1 while backpressure is enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) begin
                bp_rdy = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                bp_rdy = 1'b1;
                ph = 0;
            end
        end
    end

    always @(negedge clk) if (bus_a.frame_err) errcnt++;

    // Monitor A
    logic [38:0] held_a;
    bit          stall_a = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_a = 0;
            end else begin
                if (stall_a)
                    chk("hold_a", {bus_a.out_valid, bus_a.out_re, bus_a.out_im, bus_a.out_idx}, held_a);
                if (bus_a.out_valid && bus_a.out_ready) begin
                    if (q_a.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_a: idx %0d re %0d, nothing expected", bus_a.out_idx, bus_a.out_re);
                    end else begin
                        e = q_a.pop_front();
                        chk("re_a", bus_a.out_re, e.re);
                        chk("im_a", bus_a.out_im, e.im);
                        chk("idx_a", bus_a.out_idx, e.idx);
                        chk("first_a", bus_a.out_first, e.idx == 0);
                        chk("last_a", bus_a.out_last, e.idx == 63);
                    end
                    take_cyc.push_back(cyc + 1);
                end
                stall_a = bus_a.out_valid && !bus_a.out_ready;
                held_a  = {bus_a.out_valid, bus_a.out_re, bus_a.out_im, bus_a.out_idx};
            end
        end
    end

    // Monitor B
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus_b.out_valid && bus_b.out_ready) begin
                if (q_b.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_b: idx %0d re %0d, nothing expected", bus_b.out_idx, bus_b.out_re);
                end else begin
                    e = q_b.pop_front();
                    chk("re_b", bus_b.out_re, e.re);
                    chk("im_b", bus_b.out_im, e.im);
                    chk("idx_b", bus_b.out_idx, e.idx);
                    chk("first_b", bus_b.out_first, e.idx == 0);
                    chk("last_b", bus_b.out_last, e.idx == 7);
                end
            end
        end
    end

    // Callers enter aligned at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic put_a(input bit st, input logic [15:0] r0, i0, r1, i1);
        int g = 0;
        bus_a.in_valid = 1'b1;
        bus_a.in_start = st;
        bus_a.in_re0 = r0;
        bus_a.in_im0 = i0;
        bus_a.in_re1 = r1;
        bus_a.in_im1 = i1;
        @(negedge clk);
        while (!bus_a.in_ready) begin
            g++;
            if (g > 3000) die("put_a_ready");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        acc_cyc.push_back(cyc);
    endtask

    task automatic put_b(input bit st, input logic [15:0] r0, i0, r1, i1);
        int g = 0;
        bus_b.in_valid = 1'b1;
        bus_b.in_start = st;
        bus_b.in_re0 = r0;
        bus_b.in_im0 = i0;
        bus_b.in_re1 = r1;
        bus_b.in_im1 = i1;
        @(negedge clk);
        while (!bus_b.in_ready) begin
            g++;
            if (g > 3000) die("put_b_ready");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // Position p carries bin br6(p); sample value is base + bin.
    task automatic send_a(input int base, input int npairs);
        logic [15:0] r0;
        logic [15:0] r1;
        for (int k = 0; k < npairs; k++) begin
            r0 = 16'(base + int'(br6(2*k)));
            r1 = 16'(base + int'(br6(2*k+1)));
            put_a(k == 0, r0, ~r0, r1, ~r1);
        end
    endtask

    task automatic exp_a(input int base, input int cnt);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            e.re = 16'(base + i);
            e.im = ~e.re;
            e.idx = i;
            q_a.push_back(e);
        end
    endtask

    task automatic idle_a();
        bus_a.in_valid = 1'b0;
        bus_a.in_start = 1'b0;
    endtask

    task automatic drain_a();
        int g = 0;
        while (q_a.size() != 0) begin
            g++;
            if (g > 5000) die("drain_a");
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   g;
        int   nv;
        exp_t e;
        {bus_a.in_valid, bus_a.in_start} = '0;
        {bus_a.in_re0, bus_a.in_im0, bus_a.in_re1, bus_a.in_im1} = '0;
        {bus_b.in_valid, bus_b.in_start} = '0;
        {bus_b.in_re0, bus_b.in_im0, bus_b.in_re1, bus_b.in_im1} = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus_a.in_ready, 0);
        chk("rst_out_valid", bus_a.out_valid, 0);
        chk("rst_out_re", bus_a.out_re, 0);
        chk("rst_out_im", bus_a.out_im, 0);
        chk("rst_out_idx", bus_a.out_idx, 0);
        chk("rst_out_first", bus_a.out_first, 0);
        chk("rst_out_last", bus_a.out_last, 0);
        chk("rst_frame_err", bus_a.frame_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready_a", bus_a.in_ready, 1);
        chk("post_rst_ready_b", bus_b.in_ready, 1);
        @(posedge clk);
        #1;

        // natural order and first-output latency
        exp_a(0, 64);
        send_a(0, 32);
        idle_a();
        @(negedge clk);
        chk("lat_e_valid", bus_a.out_valid, 0);
        @(negedge clk);
        chk("lat_e1_valid", bus_a.out_valid, 1);
        chk("lat_e1_idx", bus_a.out_idx, 0);
        chk("lat_e1_first", bus_a.out_first, 1);
        drain_a();

        // back-to-back frames
        acc_cyc.delete();
        take_cyc.delete();
        exp_a(256, 64);
        exp_a(512, 64);
        exp_a(768, 64);
        send_a(256, 32);
        send_a(512, 32);
        idle_a();
        @(negedge clk);
        chk("b2b_ready_low", bus_a.in_ready, 0);
        @(posedge clk);
        #1;
        send_a(768, 32);
        idle_a();
        drain_a();
        chk("b2b_ab_span", acc_cyc[63] - acc_cyc[0], 63);
        chk("b2b_latency", take_cyc[0] - acc_cyc[31], 2);
        chk("b2b_c_after_a", acc_cyc[64] > take_cyc[63], 1);
        chk("b2b_out_count", take_cyc.size(), 192);
        chk("b2b_out_span", take_cyc[191] - take_cyc[0], 191);

        // backpressure 1,0,0,1
        exp_a(1024, 64);
        bp_on = 1'b1;
        send_a(1024, 32);
        idle_a();
        drain_a();
        bp_on = 1'b0;

        // truncated frame then full frame
        errcnt = 0;
        exp_a(1280, 64);
        send_a(2000, 10);
        send_a(1280, 32);
        idle_a();
        drain_a();
        chk("trunc_err_pulses", errcnt, 1);
        chk("trunc_idle_after", bus_a.out_valid, 0);

        // reset while idx 20 is presented
        exp_a(1536, 20);
        send_a(1536, 32);
        idle_a();
        g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
            if (g > 500) die("wait_idx20");
        end while (!(bus_a.out_valid && bus_a.out_idx == 20));
        rdy_man = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus_a.out_valid, 0);
        chk("mid_rst_ready", bus_a.in_ready, 0);
        chk("mid_rst_taken", q_a.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_man = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_after", bus_a.in_ready, 1);
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_a.out_valid) nv++;
        end
        chk("mid_rst_stale", nv, 0);
        @(posedge clk);
        #1;
        exp_a(1792, 64);
        send_a(1792, 32);
        idle_a();
        drain_a();

        // natural-order instance, N=8
        for (int i = 0; i < 8; i++) begin
            e.re = 16'(i);
            e.im = 16'(100 + i);
            e.idx = i;
            q_b.push_back(e);
        end
        for (int k = 0; k < 4; k++)
            put_b(k == 0, 16'(2*k), 16'(100 + 2*k), 16'(2*k + 1), 16'(101 + 2*k));
        bus_b.in_valid = 1'b0;
        bus_b.in_start = 1'b0;
        g = 0;
        while (q_b.size() != 0) begin
            g++;
            if (g > 500) die("drain_b");
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("b_idle_after", bus_b.out_valid, 0);

        summary();
        $finish;
    end
endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter DW, default 16: signed two's-complement width of each real/imag sample.
REQ-002 SHALL have parameter LOG2N, default 6: log2 of frame length N (legal 2..10; N=64 by default).
REQ-003 SHALL have parameter BITREV, default 1: 1 means input position p carries bin bitrev(p); 0 means it carries bin p.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  input pair present this cycle.
REQ-007 in_ready  output  1  block accepts a pair this cycle; transfer happens when in_valid & in_ready.
REQ-008 in_start  input  1  qualifies the accepted pair as pair 0 of a frame.
REQ-009 in_re0, in_im0, in_re1, in_im1  input  DW each  lane0 = stream position 2k, lane1 = position 2k+1.
REQ-010 out_valid  output  1  output sample present.
REQ-011 out_ready  input  1  consumer accepts; transfer happens when out_valid & out_ready.
REQ-012 out_re, out_im  output  DW each  output sample.
REQ-013 out_idx  output  LOG2N  natural-order bin index of the output sample.
REQ-014 out_first, out_last  output  1 each  high with idx 0 and idx N-1 respectively.
REQ-015 frame_err  output  1  one-cycle pulse on a truncated frame.

Function
REQ-016 SHALL hold two banks of N complex entries (ping-pong); each bank is EMPTY, FILLING, FULL or DRAINING.
REQ-017 Write side SHALL accept N/2 pairs per frame; pair k writes lane0 to bin b(2k) and lane1 to bin b(2k+1), b=bitrev when BITREV=1, identity otherwise.
REQ-018 Accepted pairs without in_start while no frame is open SHALL be discarded (no write, no error).
REQ-019 in_start on an accepted pair SHALL open a frame in the write bank at pair count 0.
REQ-020 in_start accepted while a frame is open at count 1..N/2-1 SHALL pulse frame_err for one cycle, discard the partial data and restart at count 0 with that pair.
REQ-021 The accepting edge of pair N/2-1 SHALL mark the bank FULL and switch the write target to the other bank.
REQ-022 in_ready SHALL be 1 exactly when the write-target bank is EMPTY or FILLING; it is 0 while that bank is FULL or DRAINING.
REQ-023 Read side SHALL drain the oldest FULL bank in natural order, idx 0..N-1, one sample per accepted transfer.
REQ-024 If the last pair is accepted at edge E and the output is idle, out_valid SHALL be 1 with idx 0 after edge E+1.
REQ-025 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-026 With out_ready held at 1, consecutive idx SHALL appear on consecutive cycles; a second FULL bank SHALL follow idx N-1 with idx 0 of the next bank on the very next cycle (no bubble).
REQ-027 The bank SHALL become EMPTY on the edge accepting idx N-1; in_ready may rise on the following cycle (no same-cycle bypass).
REQ-028 Simultaneous write to one bank and drain of the other SHALL proceed independently.
REQ-029 Data SHALL pass bit-exact; there is no arithmetic or rounding.
REQ-030 Sustained throughput SHALL be one output per cycle; input duty is limited to 50% by in_ready.

Reset
REQ-031 rst=1 SHALL immediately force in_ready=0, out_valid=0, out_re=0, out_im=0, out_idx=0, out_first=0, out_last=0 and frame_err=0.
REQ-032 rst=1 SHALL set both banks EMPTY, close any open frame, and clear the write target to bank 0 and the read target to bank 0.
REQ-033 Bank storage contents need not be reset.
REQ-034 in_ready SHALL be 1 from the first edge after rst deasserts; reset mid-frame or mid-drain SHALL discard all frames.

Verification
REQ-035 Natural order (defaults): 32 pairs, pair k re0=bitrev6(2k), re1=bitrev6(2k+1), im=~re -> out_re=0..63 in order, out_im=~out_re, out_first at idx 0, out_last at idx 63, first out_valid after edge E+1.
REQ-036 Back-to-back: three frames offered continuously with out_ready=1 -> frames A and B accepted in 64 cycles, in_ready=0 while A drains, frame C accepted after A's idx 63; 192 outputs with no gap between A and B.
REQ-037 Backpressure: out_ready toggled 1,0,0,1 repeating -> no sample lost or duplicated, outputs held while stalled, idx strictly 0..63.
REQ-038 Truncation: in_start, 10 pairs, then in_start with a full frame -> one frame_err pulse; exactly 64 outputs, all from the second frame.
REQ-039 Reset mid-drain at idx 20 -> out_valid=0 immediately; after release in_ready=1 and no stale sample is output.
REQ-040 BITREV=0, LOG2N=3: pairs (0,1),(2,3),(4,5),(6,7) -> out_re=0..7 in order.
